// File: rtl/evo_bank_scheduler.sv
// Game-of-Life ping-pong bank scheduler: evolution tick, round start,
// and tear-free bank swap at vertical blanking with one-deep queueing.
module evo_bank_scheduler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int GEN_W    = 16,
    parameter int OVR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             vblank_start,
    input  logic             round_done,
    output logic             round_start,
    output logic             bank_sel,
    output logic             busy,
    output logic [GEN_W-1:0] generation,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_WAIT_VB,
        S_SWAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pending_q, pending_d;
    logic             bank_q, bank_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             tick;
    logic             trigger;

    always_comb begin
        tick  = run && (div_q == DIV_LAST);
        div_d = '0;
        if (run && !tick) begin
            div_d = div_q + 1'b1;
        end
        trigger = tick | (step & ~run);
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        bank_d      = bank_q;
        gen_d       = gen_q;
        ovr_d       = ovr_q;
        round_start = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (trigger || pending_q) begin
                    state_d   = S_START;
                    pending_d = pending_q & trigger;
                end
            end
            S_START: begin
                round_start = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (round_done) begin
                    state_d = S_WAIT_VB;
                end
            end
            S_WAIT_VB: begin
                if (vblank_start) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                bank_d  = ~bank_q;
                gen_d   = gen_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Busy: queue one trigger, count the rest as dropped
        if (state_q != S_IDLE && trigger) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (ovr_q != '1) begin
                ovr_d = ovr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            pending_q <= 1'b0;
            bank_q    <= 1'b0;
            gen_q     <= '0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            bank_q    <= bank_d;
            gen_q     <= gen_d;
            ovr_q     <= ovr_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign bank_sel    = bank_q;
    assign generation  = gen_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_evo_bank_scheduler.sv
// Bench for evo_bank_scheduler: directed scenarios with literal checks,
// then random stimulus against a timestamp-based generation model.
module tb_evo_bank_scheduler;

    localparam int TD   = 4;
    localparam int GW   = 2;
    localparam int OW   = 2;
    localparam int GMOD = 1 << GW;
    localparam int OMAX = (1 << OW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          step;
    logic          vblank_start;
    logic          round_done;
    logic          round_start;
    logic          bank_sel;
    logic          busy;
    logic [GW-1:0] generation;
    logic [OW-1:0] overrun_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = -1;

    evo_bank_scheduler #(
        .TICK_DIV(TD),
        .GEN_W   (GW),
        .OVR_W   (OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .vblank_start(vblank_start),
        .round_done  (round_done),
        .round_start (round_start),
        .bank_sel    (bank_sel),
        .busy        (busy),
        .generation  (generation),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d",
                     nm, cyc, act, exp);
        end
    endtask

    // Model: a generation is a window of cycles described by the
    // cycle of its start pulse, its accepted done and accepted vblank.
    bit mvalid = 0;
    bit in_gen;
    bit m_pend;
    bit m_tick;
    bit m_trig;
    int start_cyc;
    int done_cyc;
    int vb_cyc;
    int gens;
    int ovrs;
    int streak;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("round_start", 32'(round_start),
                32'(in_gen && cyc == start_cyc));
            chk("busy", 32'(busy), 32'(in_gen));
            chk("bank_sel", 32'(bank_sel), 32'(gens % 2));
            chk("generation", 32'(generation), 32'(gens % GMOD));
            chk("overrun_cnt", 32'(overrun_cnt),
                32'((ovrs > OMAX) ? OMAX : ovrs));
        end
        if (rst) begin
            mvalid    = 1;
            in_gen    = 0;
            m_pend    = 0;
            start_cyc = -10;
            done_cyc  = -1;
            vb_cyc    = -1;
            gens      = 0;
            ovrs      = 0;
            streak    = 0;
        end else if (mvalid) begin
            m_tick = run && (streak % TD == TD - 1);
            m_trig = m_tick || (step && !run);
            if (!in_gen) begin
                if (m_trig || m_pend) begin
                    in_gen    = 1;
                    start_cyc = cyc + 1;
                    done_cyc  = -1;
                    vb_cyc    = -1;
                    m_pend    = m_pend && m_trig;
                end
            end else begin
                if (m_trig) begin
                    if (!m_pend) m_pend = 1;
                    else ovrs++;
                end
                if (done_cyc < 0) begin
                    if (round_done && cyc > start_cyc)
                        done_cyc = cyc;
                end else if (vb_cyc < 0) begin
                    if (vblank_start) vb_cyc = cyc;
                end else if (cyc == vb_cyc + 1) begin
                    gens++;
                    in_gen = 0;
                end
            end
            streak = run ? streak + 1 : 0;
        end
    end

    task automatic next_cyc(input logic r, input logic ru,
                            input logic st, input logic vb,
                            input logic dn);
        @(posedge clk);
        #1;
        rst          = r;
        run          = ru;
        step         = st;
        vblank_start = vb;
        round_done   = dn;
    endtask

    logic run_r;

    initial begin
        rst          = 1'b1;
        run          = 1'b1;
        step         = 1'b0;
        vblank_start = 1'b0;
        round_done   = 1'b0;
        next_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int k = 1; k <= 75; k++) begin
            next_cyc(k == 69,
                     (k < 22) || (k == 57),
                     k == 46 || k == 57 || k == 60 ||
                     k == 63 || k == 65 || k == 67,
                     k == 18 || k == 30 || k == 41 ||
                     k == 50 || k == 53,
                     k == 15 || k == 27 || k == 38 ||
                     k == 50);
            if (k == 4) chk("s1_rs_c4", 32'(round_start), 0);
            if (k == 5) chk("s1_rs_c5", 32'(round_start), 1);
            if (k == 6) begin
                chk("s1_rs_c6", 32'(round_start), 0);
                chk("s1_busy_c6", 32'(busy), 1);
            end
            if (k == 20) begin
                chk("s1_bank_c20", 32'(bank_sel), 1);
                chk("s1_gen_c20", 32'(generation), 1);
                chk("s1_busy_c20", 32'(busy), 0);
                chk("s3_ovr_c20", 32'(overrun_cnt), 2);
            end
            if (k == 21) chk("s3_rs_c21", 32'(round_start), 1);
            if (k == 32) begin
                chk("s3_bank_c32", 32'(bank_sel), 0);
                chk("s3_gen_c32", 32'(generation), 2);
                chk("s3_busy_c32", 32'(busy), 0);
            end
            if (k == 33) chk("s3_rs_c33", 32'(round_start), 1);
            if (k == 43) begin
                chk("s3_gen_c43", 32'(generation), 3);
                chk("s3_bank_c43", 32'(bank_sel), 1);
                chk("s3_busy_c43", 32'(busy), 0);
            end
            if (k == 47) chk("s2_rs_c47", 32'(round_start), 1);
            if (k == 52) begin
                chk("s4_bank_c52", 32'(bank_sel), 1);
                chk("s4_busy_c52", 32'(busy), 1);
            end
            if (k == 55) begin
                chk("s5_gen_wrap", 32'(generation), 0);
                chk("s5_bank_c55", 32'(bank_sel), 0);
                chk("s4_busy_c55", 32'(busy), 0);
            end
            if (k == 58) chk("s2_step_run_c58", 32'(busy), 0);
            if (k == 59) chk("s2_step_run_c59", 32'(busy), 0);
            if (k == 68) chk("s5_ovr_sat", 32'(overrun_cnt), 3);
            if (k == 70) begin
                chk("s6_busy", 32'(busy), 0);
                chk("s6_bank", 32'(bank_sel), 0);
                chk("s6_gen", 32'(generation), 0);
                chk("s6_ovr", 32'(overrun_cnt), 0);
                chk("s6_rs_c70", 32'(round_start), 0);
            end
            if (k == 71) chk("s6_rs_c71", 32'(round_start), 0);
        end

        run_r = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) run_r = ~run_r;
            next_cyc($urandom_range(0, 599) == 0,
                     run_r,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 11) == 0,
                     $urandom_range(0, 6) == 0);
        end

        for (int k = 0; k < 4; k++) begin
            next_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
